// File: rtl/arc_cs_pkg.sv
// Shared encodings and fixed control-store addresses for the
// micro-sequencer and its decode map.
package arc_cs_pkg;

  localparam logic [2:0] COND_NEXT   = 3'b000;
  localparam logic [2:0] COND_N      = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_V      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;
  localparam logic [2:0] COND_IR13   = 3'b101;
  localparam logic [2:0] COND_JUMP   = 3'b110;
  localparam logic [2:0] COND_DECODE = 3'b111;

  localparam logic [1:0] CBL_NEXT   = 2'b00;
  localparam logic [1:0] CBL_JUMP   = 2'b01;
  localparam logic [1:0] CBL_DECODE = 2'b10;
  localparam logic [1:0] CBL_FAULT  = 2'b11;

  typedef enum logic {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } seq_state_e;

  localparam logic [10:0] BRANCH_ADDR  = 11'd1088;
  localparam logic [10:0] ILLEGAL_ADDR = 11'd2047;
  localparam logic [10:0] FAULT_ADDR   = 11'd2046;

  localparam logic [7:0] OP_A = 8'b10010000;
  localparam logic [7:0] OP_B = 8'b10001100;
  localparam logic [7:0] OP_C = 8'b11000000;
  localparam logic [7:0] OP_D = 8'b11000100;

endpackage

// File: rtl/cs_decode_map.sv
// Opcode byte to control-store entry point; valid low marks an
// unmapped opcode.
module cs_decode_map
  import arc_cs_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic [DW-1:0] decode,
  output logic [AW-1:0] addr,
  output logic          valid
);

  logic is_branch;
  logic is_mapped;

  assign is_branch = (decode[DW-1:DW-5] == 5'b00010);
  assign is_mapped = (decode == DW'(OP_A)) ||
                     (decode == DW'(OP_B)) ||
                     (decode == DW'(OP_C)) ||
                     (decode == DW'(OP_D));

  always_comb begin
    addr  = AW'(ILLEGAL_ADDR);
    valid = 1'b0;
    unique case (1'b1)
      is_branch: begin
        addr  = AW'(BRANCH_ADDR);
        valid = 1'b1;
      end
      is_mapped: begin
        addr  = AW'({1'b1, decode, 2'b00});
        valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Control-store address sequencer: next/jump/decode selection
// with a memory wait state and timeout fault.
module micro_sequencer
  import arc_cs_pkg::*;
#(
  parameter int DATAWIDTH_CONTROL_ADDRESS_BUS = 11,
  parameter int DATAWIDTH_SCRATCHPAD_BUS      = 8,
  parameter int TIMEOUT_CYCLES                = 255
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic [2:0]                               COND,
  input  logic [DATAWIDTH_CONTROL_ADDRESS_BUS-1:0] JUMP,
  input  logic [DATAWIDTH_SCRATCHPAD_BUS-1:0]      DECODE,
  input  logic [3:0]                               FLAGS,
  input  logic                                     IR13,
  input  logic                                     MEM_REQ,
  input  logic                                     MEM_READY,
  output logic [DATAWIDTH_CONTROL_ADDRESS_BUS-1:0] CSAR,
  output logic [1:0]                               CBL,
  output logic                                     STALL,
  output logic                                     ILLEGAL_OP,
  output logic                                     MEM_TIMEOUT
);

  localparam int AW = DATAWIDTH_CONTROL_ADDRESS_BUS;
  localparam int DW = DATAWIDTH_SCRATCHPAD_BUS;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e     state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;
  logic [AW-1:0]  csar_inc;
  logic [AW-1:0]  dec_addr;
  logic           dec_valid;
  logic           taken;
  logic [AW-1:0]  nxt_addr;
  logic [1:0]     nxt_cbl;
  logic           nxt_ill;
  logic           load;
  logic           expire;

  cs_decode_map #(
    .AW (AW),
    .DW (DW)
  ) u_map (
    .decode (DECODE),
    .addr   (dec_addr),
    .valid  (dec_valid)
  );

  assign csar_inc = CSAR + AW'(1);
  assign cnt_inc  = cnt + CW'(1);
  assign STALL    = (state == WAIT_MEM);

  always_comb begin
    taken = 1'b0;
    case (COND)
      COND_N:    taken = FLAGS[3];
      COND_Z:    taken = FLAGS[2];
      COND_V:    taken = FLAGS[1];
      COND_C:    taken = FLAGS[0];
      COND_IR13: taken = IR13;
      COND_JUMP: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt_addr = csar_inc;
    nxt_cbl  = CBL_NEXT;
    nxt_ill  = 1'b0;
    if (COND == COND_DECODE) begin
      if (dec_valid) begin
        nxt_addr = dec_addr;
        nxt_cbl  = CBL_DECODE;
      end else begin
        nxt_addr = AW'(ILLEGAL_ADDR);
        nxt_cbl  = CBL_FAULT;
        nxt_ill  = 1'b1;
      end
    end else if (taken) begin
      nxt_addr = JUMP;
      nxt_cbl  = CBL_JUMP;
    end
  end

  // Timeout fires on the TIMEOUT_CYCLES-th stalled cycle unless ready wins.
  assign load   = MEM_READY || (state == RUN && !MEM_REQ);
  assign expire = (state == WAIT_MEM) && !MEM_READY &&
                  (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= RUN;
      cnt         <= '0;
      CSAR        <= '0;
      CBL         <= CBL_NEXT;
      ILLEGAL_OP  <= 1'b0;
      MEM_TIMEOUT <= 1'b0;
    end else begin
      ILLEGAL_OP  <= 1'b0;
      MEM_TIMEOUT <= 1'b0;
      if (load) begin
        CSAR       <= nxt_addr;
        CBL        <= nxt_cbl;
        ILLEGAL_OP <= nxt_ill;
        state      <= RUN;
        cnt        <= '0;
      end else if (expire) begin
        CSAR        <= AW'(FAULT_ADDR);
        CBL         <= CBL_FAULT;
        MEM_TIMEOUT <= 1'b1;
        state       <= RUN;
        cnt         <= '0;
      end else if (state == RUN) begin
        state <= WAIT_MEM;
        cnt   <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a cycle model and
// per-cycle output comparison.
module tb_micro_sequencer;

  localparam int TMO = 255;

  logic        CLK;
  logic        RESET;
  logic [2:0]  COND;
  logic [10:0] JUMP;
  logic [7:0]  DECODE;
  logic [3:0]  FLAGS;
  logic        IR13;
  logic        MEM_REQ;
  logic        MEM_READY;
  logic [10:0] CSAR;
  logic [1:0]  CBL;
  logic        STALL;
  logic        ILLEGAL_OP;
  logic        MEM_TIMEOUT;

  int checks = 0;
  int errors = 0;

  micro_sequencer #(
    .DATAWIDTH_CONTROL_ADDRESS_BUS (11),
    .DATAWIDTH_SCRATCHPAD_BUS      (8),
    .TIMEOUT_CYCLES                (TMO)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .COND        (COND),
    .JUMP        (JUMP),
    .DECODE      (DECODE),
    .FLAGS       (FLAGS),
    .IR13        (IR13),
    .MEM_REQ     (MEM_REQ),
    .MEM_READY   (MEM_READY),
    .CSAR        (CSAR),
    .CBL         (CBL),
    .STALL       (STALL),
    .ILLEGAL_OP  (ILLEGAL_OP),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state
  int m_csar, m_cbl, m_wait;
  bit m_stall, m_ill, m_tmo, m_valid;

  function automatic int dec_target(input int op);
    if ((op >> 3) == 2) return 1088;
    if (op == 144 || op == 140 || op == 192 || op == 196)
      return 1024 + op * 4;
    return -1;
  endfunction

  task automatic model_load();
    int t;
    bit fl [8];
    fl[0] = 0;
    fl[1] = FLAGS[3];
    fl[2] = FLAGS[2];
    fl[3] = FLAGS[1];
    fl[4] = FLAGS[0];
    fl[5] = IR13;
    fl[6] = 1;
    fl[7] = 0;
    if (COND == 7) begin
      t = dec_target(int'(DECODE));
      if (t < 0) begin
        m_csar = 2047;
        m_cbl  = 3;
        m_ill  = 1;
      end else begin
        m_csar = t;
        m_cbl  = 2;
      end
    end else if (fl[COND]) begin
      m_csar = int'(JUMP);
      m_cbl  = 1;
    end else begin
      m_csar = (m_csar + 1) % 2048;
      m_cbl  = 0;
    end
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      m_valid = 1;
      m_csar = 0; m_cbl = 0; m_wait = 0;
      m_stall = 0; m_ill = 0; m_tmo = 0;
    end else if (m_valid) begin
      m_ill = 0;
      m_tmo = 0;
      if (MEM_READY || (!m_stall && !MEM_REQ)) begin
        model_load();
        m_stall = 0;
        m_wait  = 0;
      end else if (!m_stall) begin
        m_stall = 1;
        m_wait  = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_csar = 2046;
          m_cbl  = 3;
          m_tmo  = 1;
          m_stall = 0;
          m_wait  = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_csar", int'(CSAR), m_csar);
      chk("model_cbl", int'(CBL), m_cbl);
      chk("model_stall", int'(STALL), int'(m_stall));
      chk("model_illegal", int'(ILLEGAL_OP), int'(m_ill));
      chk("model_timeout", int'(MEM_TIMEOUT), int'(m_tmo));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  logic [2:0]  c_cond [6];
  logic [3:0]  c_flag [6];
  logic        c_ir   [6];
  logic [10:0] c_jmp  [6];
  logic [7:0]  d_op   [5];
  int          d_exp  [5];

  initial begin
    c_cond = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd5, 3'd1};
    c_flag = '{4'b1000, 4'b0111, 4'b0001, 4'b0000, 4'b1111, 4'b0111};
    c_ir   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    c_jmp  = '{11'd100, 11'd900, 11'd50, 11'd7, 11'd600, 11'd33};
    d_op   = '{8'h90, 8'h16, 8'h8C, 8'hC0, 8'hC4};
    d_exp  = '{1600, 1088, 1584, 1792, 1808};

    RESET = 1; COND = 0; JUMP = 0; DECODE = 0; FLAGS = 0;
    IR13 = 0; MEM_REQ = 0; MEM_READY = 0;
    step();
    chk("reset_csar", int'(CSAR), 0);
    chk("reset_cbl", int'(CBL), 0);
    chk("reset_stall", int'(STALL), 0);

    RESET = 0;
    step();
    chk("seq_1", int'(CSAR), 1);
    step(2);
    chk("seq_3", int'(CSAR), 3);
    chk("seq_cbl", int'(CBL), 0);
    step(2);
    chk("at_5", int'(CSAR), 5);

    COND = 3'd2; JUMP = 11'd300; FLAGS = 4'b0100;
    step();
    chk("z_taken", int'(CSAR), 300);
    chk("z_taken_cbl", int'(CBL), 1);
    COND = 3'd6; JUMP = 11'd5;
    step();
    COND = 3'd2; JUMP = 11'd300; FLAGS = 4'b0000;
    step();
    chk("z_not", int'(CSAR), 6);
    chk("z_not_cbl", int'(CBL), 0);

    for (int i = 0; i < 6; i++) begin
      COND = c_cond[i]; FLAGS = c_flag[i];
      IR13 = c_ir[i]; JUMP = c_jmp[i];
      step();
    end

    COND = 3'd7;
    for (int i = 0; i < 5; i++) begin
      DECODE = d_op[i];
      step();
      chk("decode_addr", int'(CSAR), d_exp[i]);
      chk("decode_cbl", int'(CBL), 2);
    end
    DECODE = 8'hFF;
    step();
    chk("illegal_addr", int'(CSAR), 2047);
    chk("illegal_cbl", int'(CBL), 3);
    chk("illegal_pulse", int'(ILLEGAL_OP), 1);
    COND = 3'd0;
    step();
    chk("wrap", int'(CSAR), 0);
    chk("illegal_once", int'(ILLEGAL_OP), 0);

    COND = 3'd6; JUMP = 11'd2047;
    step();
    RESET = 1; COND = 3'd0;
    step();
    chk("rst_2047_csar", int'(CSAR), 0);
    chk("rst_2047_stall", int'(STALL), 0);
    RESET = 0;

    MEM_REQ = 1; MEM_READY = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_stall", int'(STALL), 1);
      chk("wait_hold", int'(CSAR), 0);
    end
    MEM_READY = 1;
    step();
    chk("wait_adv", int'(CSAR), 1);
    chk("wait_unstall", int'(STALL), 0);

    MEM_READY = 0;
    step();
    COND = 3'd6; JUMP = 11'd77; MEM_READY = 1;
    step();
    chk("wait_sample", int'(CSAR), 77);
    chk("wait_sample_cbl", int'(CBL), 1);

    COND = 3'd0; MEM_READY = 0;
    step();
    step(TMO - 1);
    chk("pre_tmo_pulse", int'(MEM_TIMEOUT), 0);
    chk("pre_tmo_stall", int'(STALL), 1);
    step();
    chk("tmo_csar", int'(CSAR), 2046);
    chk("tmo_cbl", int'(CBL), 3);
    chk("tmo_pulse", int'(MEM_TIMEOUT), 1);
    chk("tmo_stall", int'(STALL), 0);
    MEM_REQ = 0;
    step();
    chk("tmo_once", int'(MEM_TIMEOUT), 0);
    chk("after_tmo", int'(CSAR), 2047);

    MEM_REQ = 1;
    step();
    step(TMO - 1);
    MEM_READY = 1;
    step();
    chk("race_csar", int'(CSAR), 0);
    chk("race_cbl", int'(CBL), 0);
    chk("race_pulse", int'(MEM_TIMEOUT), 0);

    MEM_READY = 0;
    step(2);
    RESET = 1;
    step();
    chk("rst_wait_csar", int'(CSAR), 0);
    chk("rst_wait_stall", int'(STALL), 0);
    RESET = 0; MEM_REQ = 0;
    step();
    chk("first_load", int'(CSAR), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
